// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
// Word-addressed 32-bit RAM behind a Read/Write request, MemDone completion handshake.
// Latency: access WAIT_STATES+1 edges after acceptance, MemDone the cycle after; requests outside IDLE are ignored.
module mem_ctrl #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] MAR_addr,
  input  logic [31:0]           MDR_data_out,
  output logic [31:0]           Mdatain,
  output logic                  MemDone,
  output logic                  MemBusy,
  output logic                  MemErr
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                  op_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
  } req_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  req_t        req;
  logic [31:0] mem [DEPTH];

  logic accept;
  logic reject;
  logic access;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    access    = 1'b0;
    case (state)
      S_IDLE: begin
        if (Read && Write) begin
          reject = 1'b1;
        end else if (Read || Write) begin
          accept    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      req     <= '0;
      Mdatain <= 32'd0;
      MemErr  <= 1'b0;
    end else begin
      state  <= state_nxt;
      MemErr <= reject;
      // The request is frozen at acceptance so the MAR/MDR may move on during the wait.
      if (accept) begin
        cnt <= WAIT_INIT;
        req <= '{op_wr: Write, addr: MAR_addr, data: MDR_data_out};
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !req.op_wr) begin
        Mdatain <= mem[req.addr];
      end
    end
  end

  // Array is never cleared; Clear forces IDLE so a pending write simply never reaches its access edge.
  always_ff @(posedge Clock) begin
    if (access && req.op_wr) begin
      mem[req.addr] <= req.data;
    end
  end

  assign MemBusy = (state == S_WAIT);
  assign MemDone = (state == S_DONE);

endmodule

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
// Bench for mem_ctrl: one WAIT_STATES=2 and one WAIT_STATES=0 instance against a word-array reference model.
module tb_mem_ctrl;

  logic        Clock = 1'b0;
  logic        clr;
  logic        rd   [2];
  logic        wr   [2];
  logic [8:0]  addr [2];
  logic [31:0] din  [2];
  logic [31:0] mdat [2];
  logic        done [2];
  logic        busy [2];
  logic        err  [2];

  logic [31:0] model_mem [2][512];
  bit          model_vld [2][512];
  logic [31:0] model_rd  [2];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc_cnt = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc_cnt <= cyc_cnt + 1;

  mem_ctrl #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dut0 (
    .Clock(Clock), .Clear(clr), .Read(rd[0]), .Write(wr[0]),
    .MAR_addr(addr[0]), .MDR_data_out(din[0]),
    .Mdatain(mdat[0]), .MemDone(done[0]), .MemBusy(busy[0]), .MemErr(err[0])
  );

  mem_ctrl #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut1 (
    .Clock(Clock), .Clear(clr), .Read(rd[1]), .Write(wr[1]),
    .MAR_addr(addr[1]), .MDR_data_out(din[1]),
    .Mdatain(mdat[1]), .MemDone(done[1]), .MemBusy(busy[1]), .MemErr(err[1])
  );

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // One complete transaction on instance d, request dropped in the MemDone cycle.
  task automatic do_txn(input int d, input bit is_wr, input logic [8:0] a,
                        input logic [31:0] dat, input bit scramble);
    int          done_at;
    int          nbusy;
    logic [31:0] exp;
    done_at = 0;
    nbusy   = 0;
    exp     = is_wr ? model_rd[d] : model_mem[d][a];
    rd[d]   = !is_wr;
    wr[d]   = is_wr;
    addr[d] = a;
    din[d]  = dat;
    @(negedge Clock);
    for (int c = 1; c <= 20 && done_at == 0; c++) begin
      if (done[d] === 1'b1) begin
        done_at = c;
      end else begin
        if (busy[d] === 1'b1) nbusy++;
        if (scramble) begin
          addr[d] = (c == 1) ? a + 9'd1 : a ^ 9'($urandom_range(1, 511));
          din[d]  = $urandom;
        end
        @(negedge Clock);
      end
    end
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    n_cmp++;
    if (done_at != ws_of(d) + 2) begin
      n_err++;
      $display("FAIL latency d%0d a=%h: MemDone at cycle %0d, want %0d", d, a, done_at, ws_of(d) + 2);
    end
    n_cmp++;
    if (nbusy != ws_of(d) + 1) begin
      n_err++;
      $display("FAIL busy_cycles d%0d a=%h: got %0d, want %0d", d, a, nbusy, ws_of(d) + 1);
    end
    n_cmp++;
    if (mdat[d] !== exp) begin
      n_err++;
      $display("FAIL mdatain d%0d %s a=%h: got %h, want %h", d, is_wr ? "wr" : "rd", a, mdat[d], exp);
    end
    n_cmp++;
    if (err[d] !== 1'b0) begin
      n_err++;
      $display("FAIL err_quiet d%0d: MemErr got %b, want 0", d, err[d]);
    end
    if (is_wr) begin
      model_mem[d][a] = dat;
      model_vld[d][a] = 1'b1;
    end else begin
      model_rd[d] = exp;
    end
    @(negedge Clock);
    n_cmp++;
    if (done[d] !== 1'b0 || mdat[d] !== model_rd[d]) begin
      n_err++;
      $display("FAIL done_pulse d%0d: MemDone %b Mdatain %h, want 0 and %h", d, done[d], mdat[d], model_rd[d]);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; din[d] = '0;
      model_rd[d] = 32'd0;
    end
    repeat (2) @(negedge Clock);
    clr = 1'b0;
    @(negedge Clock);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({mdat[d], done[d], busy[d], err[d]} !== 35'd0) begin
        n_err++;
        $display("FAIL reset d%0d: Mdatain %h Done %b Busy %b Err %b, want all 0", d, mdat[d], done[d], busy[d], err[d]);
      end
    end
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b1, 9'h05, 32'hDEADBEEF, 1'b0);
    do_txn(0, 1'b0, 9'h05, 32'h0, 1'b0);
    n_cmp++;
    if (mdat[0] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_read: Mdatain %h, want deadbeef", mdat[0]);
    end
  endtask

  task automatic test_capture();
    do_txn(0, 1'b1, 9'h06, 32'h0BADF00D, 1'b0);
    do_txn(0, 1'b0, 9'h05, 32'h0, 1'b1);
    do_txn(0, 1'b1, 9'h07, 32'h13572468, 1'b1);
    do_txn(0, 1'b0, 9'h07, 32'h0, 1'b0);
  endtask

  task automatic test_simultaneous();
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 9'h05; din[0] = $urandom;
    @(negedge Clock);
    n_cmp++;
    if (err[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0 || mdat[0] !== model_rd[0]) begin
      n_err++;
      $display("FAIL simult_reject: Err %b Busy %b Done %b Mdatain %h, want 1 0 0 %h", err[0], busy[0], done[0], mdat[0], model_rd[0]);
    end
    rd[0] = 1'b0; wr[0] = 1'b0;
    @(negedge Clock);
    n_cmp++;
    if (err[0] !== 1'b0 || done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL simult_pulse: Err %b Done %b Busy %b, want 0 0 0", err[0], done[0], busy[0]);
    end
    do_txn(0, 1'b0, 9'h05, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    logic [8:0] a;
    int         q[$];
    for (int i = 0; i < 16; i++) begin
      if (q.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = 9'($urandom);
        do_txn(0, 1'b1, a, $urandom, 1'($urandom_range(0, 1)));
        q.push_back(int'(a));
      end else begin
        a = 9'(q[$urandom_range(0, q.size() - 1)]);
        do_txn(0, 1'b0, a, 32'h0, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic test_idle_clear();
    @(negedge Clock);
    clr = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({mdat[d], done[d], busy[d], err[d]} !== 35'd0) begin
        n_err++;
        $display("FAIL idle_clear d%0d: Mdatain %h Done %b Busy %b Err %b, want all 0", d, mdat[d], done[d], busy[d], err[d]);
      end
      model_rd[d] = 32'd0;
    end
    @(negedge Clock);
    clr = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_reset_mid_write();
    do_txn(0, 1'b1, 9'h10, 32'hAAAA0000, 1'b0);
    wr[0] = 1'b1; addr[0] = 9'h10; din[0] = 32'h12345678;
    repeat (2) @(negedge Clock);
    n_cmp++;
    if (busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midwr_busy: MemBusy %b, want 1", busy[0]);
    end
    clr = 1'b1;
    wr[0] = 1'b0;
    #1;
    n_cmp++;
    if ({mdat[0], done[0], busy[0], err[0]} !== 35'd0) begin
      n_err++;
      $display("FAIL midwr_clear: Mdatain %h Done %b Busy %b Err %b, want all 0", mdat[0], done[0], busy[0], err[0]);
    end
    model_rd[0] = 32'd0;
    model_rd[1] = 32'd0;
    @(negedge Clock);
    clr = 1'b0;
    @(negedge Clock);
    do_txn(0, 1'b0, 9'h10, 32'h0, 1'b0);
    n_cmp++;
    if (mdat[0] !== 32'hAAAA0000) begin
      n_err++;
      $display("FAIL midwr_keep: Mdatain %h, want aaaa0000", mdat[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  a_list[4];
    logic [31:0] exp;
    int          prev;
    a_list[0] = 9'h000;
    a_list[1] = 9'h001;
    a_list[2] = 9'($urandom_range(2, 511));
    a_list[3] = 9'($urandom_range(2, 511));
    for (int i = 0; i < 4; i++) do_txn(1, 1'b1, a_list[i], $urandom, 1'b0);
    prev = 0;
    rd[1] = 1'b1;
    addr[1] = a_list[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      for (int t = 0; t < 8 && done[1] !== 1'b1; t++) @(negedge Clock);
      n_cmp++;
      if (done[1] !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_timeout read %0d: MemDone %b, want 1", i, done[1]);
      end
      exp = model_mem[1][a_list[i]];
      n_cmp++;
      if (mdat[1] !== exp) begin
        n_err++;
        $display("FAIL b2b_data read %0d a=%h: got %h, want %h", i, a_list[i], mdat[1], exp);
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc_cnt - prev != 3) begin
          n_err++;
          $display("FAIL b2b_period read %0d: got %0d cycles, want 3", i, cyc_cnt - prev);
        end
      end
      prev = cyc_cnt;
      model_rd[1] = exp;
      if (i < 3) addr[1] = a_list[i + 1];
      else rd[1] = 1'b0;
    end
    @(negedge Clock);
    n_cmp++;
    if (done[1] !== 1'b0 || mdat[1] !== model_rd[1]) begin
      n_err++;
      $display("FAIL b2b_end: MemDone %b Mdatain %h, want 0 and %h", done[1], mdat[1], model_rd[1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_capture();
    test_simultaneous();
    test_random();
    test_idle_clear();
    test_reset_mid_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Word-addressed 32-bit RAM with a multi-cycle request/done handshake. It sits directly upstream of the MDR and supplies its `Mdatain` on reads. It consumes the MDR's `MDR_data_out` and the MAR address on writes. The control unit raises `Read` or `Write`, holds the MDR load until `MemDone` pulses, then drops the request.

## Interface

Parameters:
- ADDR_WIDTH, 9, address bits; memory depth is 2^ADDR_WIDTH words of 32 bits.
- WAIT_STATES, 2, extra idle cycles inserted before the array access (legal range 0–15).

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- Clear  in  1  asynchronous, active-high reset.
- Read  in  1  read request, level.
- Write  in  1  write request, level.
- MAR_addr  in  ADDR_WIDTH  word address, taken from the MAR.
- MDR_data_out  in  32  write data, taken from the MDR.
- Mdatain  out  32  registered read data, feeds the MDR.
- MemDone  out  1  one-cycle pulse: transaction complete.
- MemBusy  out  1  high while a transaction is waiting.
- MemErr  out  1  one-cycle pulse: illegal request rejected.

## Operation

- **States:** IDLE, WAIT, DONE. A 4-bit wait counter `cnt` is used in WAIT.
- **IDLE, exactly one of Read/Write high at an edge:**
  - Accept the request.
  - Capture op, `MAR_addr` and `MDR_data_out` into internal registers.
  - Load `cnt` with WAIT_STATES and go to WAIT.
- **IDLE, Read and Write both high at an edge:**
  - Reject the request; no capture, no array access.
  - Pulse MemErr for one cycle and stay in IDLE.
- **IDLE, neither request high:** stay in IDLE.
- **WAIT, cnt ≠ 0:** decrement `cnt`.
- **WAIT, cnt = 0:** perform the access with the captured address and data, then go to DONE.
  - Read: Mdatain <= mem[addr].
  - Write: mem[addr] <= data.
- **DONE:** MemDone = 1 for this one cycle, then go to IDLE unconditionally.
- **Captured values:** changes on MAR_addr, MDR_data_out, Read or Write after acceptance have no effect on the current transaction.
- **Requests outside IDLE:** ignored.
- **Request still high when back in IDLE:** treated as a new transaction. The control unit must deassert the request in the MemDone cycle.
- **Mdatain hold behaviour:**
  - Holds the last completed read value.
  - Writes and rejected requests never change it.
  - A write followed by a read of the same address returns the new data.
- **Address range:** the full address range is valid; there is no out-of-range case.
- **Array:** 2^ADDR_WIDTH x 32 register array. Clear does not clear its contents, and no initialisation is defined.

## Timing

- **Reset values:** state = IDLE, cnt = 0, Mdatain = 0, MemDone = 0, MemBusy = 0, MemErr = 0.
- **MemBusy** = (state == WAIT), decoded combinationally from the state register.
- **MemDone** = (state == DONE), decoded combinationally from the state register.
- **MemErr** is a registered pulse, high in the cycle after the rejecting edge.
- **Latency:**
  - Request sampled at edge k.
  - Array access at edge k+WAIT_STATES+1.
  - MemDone high during the cycle after that edge. Mdatain is valid in the same cycle and stays stable afterwards.
  - Back-to-back minimum period per transaction: WAIT_STATES+3 cycles.
- **WAIT_STATES = 0:** accept at k, access at k+1, MemDone high in the cycle after k+1.
- **Clear asserted mid-transaction:**
  - Immediate return to IDLE and all outputs to reset values.
  - A write whose access edge has not yet occurred is not performed, so memory keeps its old value.
- **Clear released:** the first edge with Clear low may accept a request.
- **Downstream handoff:** the MDR loads Mdatain on the MemDone cycle edge, with MDRin and Read held high by the control unit.

## Test plan

- **Reset values:** Clear pulse mid-idle -> Mdatain = 0, MemDone/MemBusy/MemErr = 0, state IDLE.
- **Write then read, WAIT_STATES = 2:**
  - Write 0xDEADBEEF to addr 0x05 -> MemBusy high 3 cycles, MemDone pulses once, Mdatain unchanged.
  - Then read addr 0x05 -> Mdatain = 0xDEADBEEF in the MemDone cycle.
- **Capture check:** read addr 0x05 while MAR_addr changes to 0x06 during WAIT -> data returned from 0x05, not 0x06.
- **Simultaneous requests:** Read = Write = 1 in IDLE -> MemErr one-cycle pulse, no MemDone, memory and Mdatain unchanged.
- **Reset mid-write:**
  - Write 0x12345678 to addr 0x10, holding 0xAAAA0000; assert Clear on the second WAIT cycle -> outputs return to reset values.
  - Subsequent read of 0x10 returns 0xAAAA0000.
- **WAIT_STATES = 0 instance:** back-to-back reads of 0x00 then 0x01 with the request held high -> MemDone every 3 cycles with the correct data each time.
